// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode/funct constants and register indices
package mips_defs;

    localparam logic [5:0] OP_ROP  = 6'b000000;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FUNCT_ADDU = 6'b100001;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Return address written by jal: the instruction after the delay slot.
    function automatic logic [31:0] link_addr(input logic [31:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - sub-word load lane select and sign/zero extension
module load_ext
    import mips_defs::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lanes: byte 0 is word[7:0]; offset[0] is ignored for halves.
    assign byte_sel = word[8*offset +: 8];
    assign half_sel = word[16*offset[1] +: 16];

    always_comb begin
        data = word;
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'd0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register; MEM_WB_LOAD_EXT_EN adds lb/lbu/lh/lhu
module mem_wb_reg
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [5:0]  in_op,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_mem,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        fwd_we,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data,
    output logic [31:0] retired
);

    logic [4:0]  cap_addr;
    logic [31:0] cap_data;
    logic        cap_we;
    logic        unused_funct;

    // Writeback data does not depend on funct; the port exists for decode symmetry.
    assign unused_funct = ^in_funct;

`ifdef MEM_WB_LOAD_EXT_EN
    logic [31:0] ext_data;

    load_ext u_load_ext (
        .op     (in_op),
        .offset (in_alu[1:0]),
        .word   (in_mem),
        .data   (ext_data)
    );
`endif

    always_comb begin
        cap_addr = (in_op == OP_JAL) ? REG_RA : in_rd;
        cap_we   = in_valid & in_regwrite & (cap_addr != REG_ZERO);
        cap_data = in_alu;
        case (in_op)
            OP_LW:  cap_data = in_mem;
            OP_JAL: cap_data = link_addr(in_pc);
`ifdef MEM_WB_LOAD_EXT_EN
            OP_LB, OP_LBU, OP_LH, OP_LHU: cap_data = ext_data;
`endif
            default: cap_data = in_alu;
        endcase
    end

    // Flush wins over stall; a flushed slot is zeroed rather than left stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_pc    <= 32'd0;
            wb_we    <= 1'b0;
            wb_addr  <= 5'd0;
            wb_data  <= 32'd0;
            retired  <= 32'd0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_pc    <= 32'd0;
            wb_we    <= 1'b0;
            wb_addr  <= 5'd0;
            wb_data  <= 32'd0;
        end else if (!stall) begin
            wb_valid <= in_valid;
            wb_pc    <= in_pc;
            wb_we    <= cap_we;
            wb_addr  <= cap_addr;
            wb_data  <= cap_data;
            retired  <= retired + {31'd0, in_valid};
        end
    end

    assign fwd_we   = wb_we;
    assign fwd_addr = wb_addr;
    assign fwd_data = wb_data;

endmodule

// File: tb/tb_mem_wb_reg.sv
// tb/tb_mem_wb_reg.sv - directed self-checking bench for mem_wb_reg
module tb_mem_wb_reg;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [5:0]  in_op;
    logic [5:0]  in_funct;
    logic [31:0] in_alu;
    logic [31:0] in_mem;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fwd_we;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    mem_wb_reg dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_op       (in_op),
        .in_funct    (in_funct),
        .in_alu      (in_alu),
        .in_mem      (in_mem),
        .in_rd       (in_rd),
        .in_regwrite (in_regwrite),
        .wb_valid    (wb_valid),
        .wb_pc       (wb_pc),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .fwd_we      (fwd_we),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [5:0] op,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] rd, input logic rw);
        in_valid    = v;
        in_pc       = pc;
        in_op       = op;
        in_funct    = 6'b100001;
        in_alu      = alu;
        in_mem      = mem;
        in_rd       = rd;
        in_regwrite = rw;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic [31:0] ret);
        check({tag, ".valid"},   {31'd0, wb_valid}, {31'd0, v});
        check({tag, ".pc"},      wb_pc, pc);
        check({tag, ".we"},      {31'd0, wb_we}, {31'd0, we});
        check({tag, ".addr"},    {27'd0, wb_addr}, {27'd0, addr});
        check({tag, ".data"},    wb_data, data);
        check({tag, ".retired"}, retired, ret);
        check({tag, ".fwd_we"},   {31'd0, fwd_we}, {31'd0, we});
        check({tag, ".fwd_addr"}, {27'd0, fwd_addr}, {27'd0, addr});
        check({tag, ".fwd_data"}, fwd_data, data);
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        // Instruction presented during reset must be lost.
        drive(1'b1, 32'h0000_1000, 6'b100011, 32'h0, 32'h1234_5678, 5'd4, 1'b1);
        tick();
        tick();
        check_out("reset", 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd0);

        rst = 1'b0;
        drive(1'b1, 32'h0000_2000, 6'b100011, 32'h0000_0040, 32'hDEAD_BEEF, 5'd8, 1'b1);
        tick();
        check_out("lw", 1'b1, 32'h0000_2000, 1'b1, 5'd8, 32'hDEAD_BEEF, 32'd1);

        drive(1'b1, 32'h0000_3000, 6'b000011, 32'h0000_0077, 32'h0, 5'd5, 1'b1);
        tick();
        check_out("jal", 1'b1, 32'h0000_3000, 1'b1, 5'd31, 32'h0000_3008, 32'd2);

        drive(1'b1, 32'hFFFF_FFFC, 6'b000011, 32'h0, 32'h0, 5'd0, 1'b1);
        tick();
        check_out("jal_wrap", 1'b1, 32'hFFFF_FFFC, 1'b1, 5'd31, 32'h0000_0004, 32'd3);

        drive(1'b1, 32'h0000_4000, 6'b000000, 32'h0000_0005, 32'hAAAA_AAAA, 5'd0, 1'b1);
        tick();
        check_out("addu_r0", 1'b1, 32'h0000_4000, 1'b0, 5'd0, 32'h0000_0005, 32'd4);

        stall = 1'b1;
        drive(1'b1, 32'h0000_5000, 6'b100011, 32'h0, 32'h5555_5555, 5'd9, 1'b1);
        tick();
        check_out("stall1", 1'b1, 32'h0000_4000, 1'b0, 5'd0, 32'h0000_0005, 32'd4);
        drive(1'b1, 32'h0000_6000, 6'b001101, 32'h0000_00FF, 32'h0, 5'd10, 1'b1);
        tick();
        check_out("stall2", 1'b1, 32'h0000_4000, 1'b0, 5'd0, 32'h0000_0005, 32'd4);

        flush = 1'b1;
        drive(1'b1, 32'h0000_7000, 6'b100011, 32'h0, 32'h1111_1111, 5'd11, 1'b1);
        tick();
        check_out("stall_flush", 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd4);
        stall = 1'b0;
        flush = 1'b0;

        drive(1'b0, 32'h0000_8000, 6'b000000, 32'h0000_0099, 32'h0, 5'd3, 1'b1);
        tick();
        check_out("invalid", 1'b0, 32'h0000_8000, 1'b0, 5'd3, 32'h0000_0099, 32'd4);

`ifdef MEM_WB_LOAD_EXT_EN
        drive(1'b1, 32'h0000_9000, 6'b100000, 32'h0000_1003, 32'h80FF_7F01, 5'd12, 1'b1);
        tick();
        check_out("lb_off3", 1'b1, 32'h0000_9000, 1'b1, 5'd12, 32'hFFFF_FF80, 32'd5);
        drive(1'b1, 32'h0000_9004, 6'b100100, 32'h0000_1001, 32'h80FF_7F01, 5'd13, 1'b1);
        tick();
        check_out("lbu_off1", 1'b1, 32'h0000_9004, 1'b1, 5'd13, 32'h0000_007F, 32'd6);
        drive(1'b1, 32'h0000_9008, 6'b100001, 32'h0000_1002, 32'h80FF_7F01, 5'd14, 1'b1);
        tick();
        check_out("lh_off2", 1'b1, 32'h0000_9008, 1'b1, 5'd14, 32'hFFFF_80FF, 32'd7);
        drive(1'b1, 32'h0000_900C, 6'b100101, 32'h0000_1000, 32'h80FF_7F01, 5'd15, 1'b1);
        tick();
        check_out("lhu_off0", 1'b1, 32'h0000_900C, 1'b1, 5'd15, 32'h0000_7F01, 32'd8);
`else
        drive(1'b1, 32'h0000_9000, 6'b100000, 32'h0000_1003, 32'h80FF_7F01, 5'd12, 1'b1);
        tick();
        check_out("lb_noext", 1'b1, 32'h0000_9000, 1'b1, 5'd12, 32'h0000_1003, 32'd5);
`endif

        // Asynchronous reset pulse between edges while wb_valid=1.
        stall = 1'b1;
        drive(1'b1, 32'h0000_A000, 6'b100011, 32'h0, 32'hCAFE_F00D, 5'd16, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check_out("stall_after_rst", 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd0);

        stall = 1'b0;
        tick();
        check_out("post_rst_lw", 1'b1, 32'h0000_A000, 1'b1, 5'd16, 32'hCAFE_F00D, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_reg.md
MEM_WB_REG -- requirements
Module: mem_wb_reg

Interface
REQ-001 SHALL have one clock; reset asynchronous, active-high: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-002 SHALL have inputs: stall 1 hold stage; flush 1 insert bubble; in_valid 1 MEM slot holds instruction; in_pc 32; in_op 6; in_funct 6; in_alu 32 ALU result/address; in_mem 32 DM read word; in_rd 5 dest reg; in_regwrite 1.
REQ-003 SHALL have outputs: wb_valid 1; wb_pc 32; wb_we 1 regfile write enable; wb_addr 5; wb_data 32; fwd_we 1, fwd_addr 5, fwd_data 32 forwarding copy of wb_*; retired 32 retired-instruction count.

Function
REQ-004 SHALL register all stage state on rising clk; latency MEM->WB exactly one cycle.
REQ-005 Priority per edge SHALL be flush > stall > capture.
REQ-006 flush=1 SHALL clear wb_valid and wb_we next cycle; other wb_* don't-care, held at 0.
REQ-007 stall=1, flush=0 SHALL hold every output register unchanged.
REQ-008 Capture SHALL load wb_valid<=in_valid, wb_pc<=in_pc, wb_addr<=(op==jal ? 31 : in_rd).
REQ-009 wb_we SHALL be in_valid & in_regwrite & (selected wb_addr != 0); writes to $0 suppressed.
REQ-010 wb_data select at capture: lw (100011) -> in_mem; jal (000011) -> in_pc+8 mod 2^32; all others -> in_alu.
REQ-011 With LOAD_EXT_EN: lb 100000 sign-extends byte in_mem[8*in_alu[1:0]+:8]; lbu 100100 zero-extends same byte; lh 100001 sign-extends half in_mem[16*in_alu[1]+:16]; lhu 100101 zero-extends it; in_alu[0] ignored for halves.
REQ-012 Byte lanes SHALL be little-endian, matching data memory order (byte 0 = bits 7:0).
REQ-013 fwd_* SHALL equal wb_we, wb_addr, wb_data combinationally, no extra latency.
REQ-014 retired SHALL increment by 1 on each capture edge with in_valid=1; never on stall/flush edges; wraps 0xFFFFFFFF->0.
REQ-015 Simultaneous stall and flush SHALL act as flush; retired not incremented.

Reset
REQ-016 rst=1 SHALL immediately, independent of clk, force wb_valid=0, wb_we=0, wb_pc=0, wb_addr=0, wb_data=0, retired=0.
REQ-017 Deassertion SHALL take effect at the first rising clk after rst falls; an instruction presented during reset is lost.
REQ-018 Reset mid-stall SHALL discard held state; stall after reset holds reset values.

Configuration
REQ-019 Macro MEM_WB_LOAD_EXT_EN SHALL compile in REQ-011 sub-word loads.
REQ-020 Without MEM_WB_LOAD_EXT_EN, lb/lbu/lh/lhu opcodes SHALL fall to the default (in_alu) path; only lw, jal, ALU supported.

Structure
REQ-021 Opcode/funct constants (ROp, lw, sw, lb, lbu, lh, lhu, jal, ori, lui, beq) and register index 31 SHALL live in shared package/header mips_defs.
REQ-022 Load alignment/extension SHALL be a combinational sub-module load_ext (inputs op, offset[1:0], word; output 32-bit data), instantiated only under the macro.

Verification
REQ-023 rst pulse mid-cycle with wb_valid=1 -> all outputs 0 before next clk edge, retired=0.
REQ-024 lw, in_mem=0xDEADBEEF, in_rd=8, regwrite=1 -> next cycle wb_we=1, wb_addr=8, wb_data=0xDEADBEEF, retired=1.
REQ-025 jal, in_pc=0x00003000 -> wb_addr=31, wb_data=0x00003008, wb_we=1.
REQ-026 addu in_rd=0, in_alu=5 -> wb_we=0; then stall=1 two cycles with new inputs -> outputs unchanged, retired unchanged.
REQ-027 stall=1 and flush=1 same edge with valid lw -> wb_valid=0, wb_we=0, retired unchanged.
REQ-028 MEM_WB_LOAD_EXT_EN, in_mem=0x80FF7F01: lb off 3 -> 0xFFFFFF80; lbu off 1 -> 0x0000007F; lh off 2 -> 0xFFFF80FF; lhu off 0 -> 0x00007F01; without macro lb -> in_alu.
